// File: rtl/b_element_responder.sv
// b_element_responder
//
// Serves B-element read requests out of a 512 x 16-bit storage array. Requests
// (9-bit word addresses) enter a 4-entry in-order FIFO; one entry is popped per
// cycle while enabled, and the element plus the address that produced it come
// back one cycle later with a single-cycle valid pulse. The storage is loaded
// through a separate write port that takes priority over popping.
//
// Ports
//   clock               rising-edge clock
//   clear               asynchronous active-low reset
//   en                  pop enable; 0 freezes FIFO pop and storage read
//   b_element_requested request strobe
//   b_element_address   requested word address
//   req_ready           FIFO can accept a request this cycle
//   b_element           returned element data
//   b_element_valid     one-cycle pulse per returned element
//   b_element_tag       address that produced b_element
//   load_we             storage write strobe (independent of en)
//   load_addr           storage write address
//   load_data           storage write data
//   overflow            sticky flag: a request arrived while the FIFO was full
//   overflow_clr        synchronous clear of overflow
//   busy                requests queued or a return still being presented

module b_element_responder (
    input  logic        clock,
    input  logic        clear,
    input  logic        en,
    input  logic        b_element_requested,
    input  logic [8:0]  b_element_address,
    output logic        req_ready,
    output logic [15:0] b_element,
    output logic        b_element_valid,
    output logic [8:0]  b_element_tag,
    input  logic        load_we,
    input  logic [8:0]  load_addr,
    input  logic [15:0] load_data,
    output logic        overflow,
    input  logic        overflow_clr,
    output logic        busy
);

    localparam int unsigned Depth = 4;

    // Storage and FIFO payload are not reset; only control state is.
    logic [15:0] mem [512];
    logic [8:0]  fifo_q [Depth];

    logic [1:0]  wr_ptr_q, wr_ptr_d;
    logic [1:0]  rd_ptr_q, rd_ptr_d;
    logic [2:0]  count_q, count_d;
    logic        overflow_q, overflow_d;
    logic [15:0] element_q;
    logic [8:0]  tag_q;
    logic        valid_q;

    logic        push;
    logic        pop;
    logic        drop;
    logic [8:0]  head;

    // Ready comes from the registered count only, so a pop in the same cycle
    // never makes room for a request that would otherwise be refused.
    assign req_ready = (count_q < 3'd4);
    assign push      = b_element_requested & req_ready;
    assign drop      = b_element_requested & ~req_ready;
    // A storage write owns the array this cycle, so it stalls the pop.
    assign pop       = (count_q != 3'd0) & en & ~load_we;
    assign head      = fifo_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        // Two-bit pointers wrap modulo the FIFO depth naturally.
        if (push) begin
            wr_ptr_d = wr_ptr_q + 2'd1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 2'd1;
        end

        unique case ({push, pop})
            2'b10:   count_d = count_q + 3'd1;
            2'b01:   count_d = count_q - 3'd1;
            default: count_d = count_q;
        endcase
    end

    // Setting takes precedence over a clear arriving in the same cycle.
    always_comb begin
        overflow_d = overflow_q;
        if (drop) begin
            overflow_d = 1'b1;
        end else if (overflow_clr) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            wr_ptr_q   <= 2'd0;
            rd_ptr_q   <= 2'd0;
            count_q    <= 3'd0;
            overflow_q <= 1'b0;
            element_q  <= 16'd0;
            tag_q      <= 9'd0;
            valid_q    <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            valid_q    <= pop;
            if (pop) begin
                element_q <= mem[head];
                tag_q     <= head;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= b_element_address;
        end
    end

    always_ff @(posedge clock) begin
        if (load_we) begin
            mem[load_addr] <= load_data;
        end
    end

    assign b_element       = element_q;
    assign b_element_tag   = tag_q;
    assign b_element_valid = valid_q;
    assign overflow        = overflow_q;
    assign busy            = (count_q != 3'd0) | valid_q;

endmodule

// File: tb/tb_b_element_responder.sv
// Self-checking bench for b_element_responder. Expected returns are queued when
// requests are driven; a negedge monitor pops and compares each returned element.
module tb_b_element_responder;

    logic        clock = 1'b0;
    logic        clear;
    logic        en;
    logic        b_element_requested;
    logic [8:0]  b_element_address;
    logic        req_ready;
    logic [15:0] b_element;
    logic        b_element_valid;
    logic [8:0]  b_element_tag;
    logic        load_we;
    logic [8:0]  load_addr;
    logic [15:0] load_data;
    logic        overflow;
    logic        overflow_clr;
    logic        busy;

    typedef struct packed {
        logic [8:0]  tag;
        logic [15:0] data;
    } exp_t;

    exp_t        exp_q [$];
    exp_t        mon_e;
    logic [15:0] model_mem [32];
    int          checks   = 0;
    int          failures = 0;
    int          returns  = 0;

    always #5 clock = ~clock;

    b_element_responder dut (
        .clock               (clock),
        .clear               (clear),
        .en                  (en),
        .b_element_requested (b_element_requested),
        .b_element_address   (b_element_address),
        .req_ready           (req_ready),
        .b_element           (b_element),
        .b_element_valid     (b_element_valid),
        .b_element_tag       (b_element_tag),
        .load_we             (load_we),
        .load_addr           (load_addr),
        .load_data           (load_data),
        .overflow            (overflow),
        .overflow_clr        (overflow_clr),
        .busy                (busy)
    );

    // Scoreboard monitor: every valid pulse must match the oldest expectation.
    always @(negedge clock) begin
        if (clear === 1'b1 && b_element_valid === 1'b1) begin
            returns++;
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL return_unexpected got tag=%0d data=%h, required no return",
                         b_element_tag, b_element);
            end else begin
                mon_e = exp_q.pop_front();
                if (b_element_tag !== mon_e.tag || b_element !== mon_e.data) begin
                    failures++;
                    $display("FAIL return_data got tag=%0d data=%h, required tag=%0d data=%h",
                             b_element_tag, b_element, mon_e.tag, mon_e.data);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog simulation did not finish, required finish");
        $fatal(1);
    end

    task automatic cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic push_exp(input logic [8:0] a);
        exp_t e;
        e.tag  = a;
        e.data = model_mem[a[4:0]];
        exp_q.push_back(e);
    endtask

    task automatic do_load(input logic [8:0] a, input logic [15:0] d);
        load_we   = 1'b1;
        load_addr = a;
        load_data = d;
        model_mem[a[4:0]] = d;
        cycle();
        load_we = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while ((busy !== 1'b0 || exp_q.size() != 0) && n < 20) begin
            cycle();
            n++;
        end
        checks++;
        if (busy !== 1'b0 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL %s_drain got busy=%0b pending=%0d, required busy=0 pending=0",
                     name, busy, exp_q.size());
        end
    endtask

    task automatic test_reset();
        clear = 1'b0; en = 1'b1; b_element_requested = 1'b0; b_element_address = '0;
        load_we = 1'b0; load_addr = '0; load_data = '0; overflow_clr = 1'b0;
        #2;
        checks++; if (req_ready !== 1'b1) begin failures++;
            $display("FAIL reset_req_ready got=%0b required=1", req_ready); end
        checks++; if (busy !== 1'b0) begin failures++;
            $display("FAIL reset_busy got=%0b required=0", busy); end
        checks++; if (b_element_valid !== 1'b0) begin failures++;
            $display("FAIL reset_valid got=%0b required=0", b_element_valid); end
        checks++; if (b_element !== 16'h0 || b_element_tag !== 9'h0) begin failures++;
            $display("FAIL reset_data got data=%h tag=%0d required 0/0", b_element, b_element_tag); end
        checks++; if (overflow !== 1'b0) begin failures++;
            $display("FAIL reset_overflow got=%0b required=0", overflow); end
        cycle();
        cycle();
        clear = 1'b1;
        for (int i = 0; i < 32; i++) begin
            do_load(9'(i), 16'hC000 + 16'(i) * 16'h0101);
        end
    endtask

    task automatic test_latency();
        do_load(9'd5, 16'h1234);
        b_element_requested = 1'b1; b_element_address = 9'd5; push_exp(9'd5);
        cycle();
        b_element_requested = 1'b0;
        checks++; if (b_element_valid !== 1'b0) begin failures++;
            $display("FAIL lat_n1_valid got=%0b required=0", b_element_valid); end
        checks++; if (busy !== 1'b1) begin failures++;
            $display("FAIL lat_n1_busy got=%0b required=1", busy); end
        cycle();
        checks++; if (b_element_valid !== 1'b1 || b_element !== 16'h1234 || b_element_tag !== 9'd5)
            begin failures++;
            $display("FAIL lat_n2 got v=%0b d=%h t=%0d required v=1 d=1234 t=5",
                     b_element_valid, b_element, b_element_tag); end
        cycle();
        checks++; if (b_element_valid !== 1'b0 || b_element !== 16'h1234 || busy !== 1'b0)
            begin failures++;
            $display("FAIL lat_hold got v=%0b d=%h busy=%0b required v=0 d=1234 busy=0",
                     b_element_valid, b_element, busy); end
    endtask

    task automatic test_overflow();
        int r0;
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            b_element_requested = 1'b1; b_element_address = 9'(i);
            if (i < 4) push_exp(9'(i));
            checks++; if (req_ready !== (i < 4)) begin failures++;
                $display("FAIL ovf_ready[%0d] got=%0b required=%0b", i, req_ready, i < 4); end
            cycle();
            checks++; if (b_element_valid !== 1'b0) begin failures++;
                $display("FAIL ovf_frozen_valid got=%0b required=0", b_element_valid); end
        end
        b_element_requested = 1'b0;
        checks++; if (overflow !== 1'b1 || req_ready !== 1'b0) begin failures++;
            $display("FAIL ovf_flag got ovf=%0b ready=%0b required ovf=1 ready=0",
                     overflow, req_ready); end
        b_element_requested = 1'b1; b_element_address = 9'd9; overflow_clr = 1'b1;
        cycle();
        b_element_requested = 1'b0;
        checks++; if (overflow !== 1'b1) begin failures++;
            $display("FAIL ovf_set_wins got=%0b required=1", overflow); end
        cycle();
        overflow_clr = 1'b0;
        checks++; if (overflow !== 1'b0) begin failures++;
            $display("FAIL ovf_clear got=%0b required=0", overflow); end
        r0 = returns;
        en = 1'b1;
        wait_drain("ovf");
        checks++; if (returns - r0 !== 4) begin failures++;
            $display("FAIL ovf_return_count got=%0d required=4", returns - r0); end
    endtask

    task automatic test_load_stall();
        en = 1'b0;
        b_element_requested = 1'b1; b_element_address = 9'd1; push_exp(9'd1);
        cycle();
        b_element_address = 9'd2; push_exp(9'd2);
        cycle();
        b_element_requested = 1'b0; en = 1'b1;
        load_we = 1'b1; load_addr = 9'd9; load_data = 16'hBEEF; model_mem[9] = 16'hBEEF;
        for (int i = 0; i < 3; i++) begin
            cycle();
            if (i == 2) load_we = 1'b0;
            checks++; if (b_element_valid !== 1'b0) begin failures++;
                $display("FAIL stall_valid[%0d] got=%0b required=0", i, b_element_valid); end
        end
        cycle();
        checks++; if (b_element_valid !== 1'b1 || b_element_tag !== 9'd1) begin failures++;
            $display("FAIL stall_resume1 got v=%0b t=%0d required v=1 t=1",
                     b_element_valid, b_element_tag); end
        cycle();
        checks++; if (b_element_valid !== 1'b1 || b_element_tag !== 9'd2) begin failures++;
            $display("FAIL stall_resume2 got v=%0b t=%0d required v=1 t=2",
                     b_element_valid, b_element_tag); end
        cycle();
        checks++; if (b_element_valid !== 1'b0) begin failures++;
            $display("FAIL stall_end_valid got=%0b required=0", b_element_valid); end
        wait_drain("stall");
    endtask

    task automatic test_raw();
        do_load(9'd7, 16'hAAAA);
        en = 1'b0;
        b_element_requested = 1'b1; b_element_address = 9'd7;
        cycle();
        b_element_requested = 1'b0; en = 1'b1;
        load_we = 1'b1; load_addr = 9'd7; load_data = 16'h5555; model_mem[7] = 16'h5555;
        push_exp(9'd7);
        cycle();
        load_we = 1'b0;
        checks++; if (b_element_valid !== 1'b0) begin failures++;
            $display("FAIL raw_stall_valid got=%0b required=0", b_element_valid); end
        cycle();
        en = 1'b0;
        checks++; if (b_element_valid !== 1'b1 || b_element !== 16'h5555) begin failures++;
            $display("FAIL raw_data got v=%0b d=%h required v=1 d=5555",
                     b_element_valid, b_element); end
        cycle();
        checks++; if (b_element_valid !== 1'b0) begin failures++;
            $display("FAIL raw_after_valid got=%0b required=0", b_element_valid); end
        en = 1'b1;
        wait_drain("raw");
    endtask

    task automatic test_clear();
        int r0;
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            b_element_requested = 1'b1; b_element_address = 9'(20 + i);
            cycle();
        end
        b_element_requested = 1'b0; en = 1'b1;
        cycle();
        checks++; if (b_element_valid !== 1'b1 || overflow !== 1'b1) begin failures++;
            $display("FAIL clr_pre got v=%0b ovf=%0b required v=1 ovf=1",
                     b_element_valid, overflow); end
        #2 clear = 1'b0;
        #1;
        checks++; if (b_element_valid !== 1'b0 || b_element !== 16'h0 || b_element_tag !== 9'h0)
            begin failures++;
            $display("FAIL clr_outputs got v=%0b d=%h t=%0d required 0/0/0",
                     b_element_valid, b_element, b_element_tag); end
        checks++; if (req_ready !== 1'b1 || busy !== 1'b0 || overflow !== 1'b0) begin failures++;
            $display("FAIL clr_status got ready=%0b busy=%0b ovf=%0b required 1/0/0",
                     req_ready, busy, overflow); end
        #4;
        r0 = returns;
        clear = 1'b1;
        b_element_requested = 1'b1; b_element_address = 9'd3; push_exp(9'd3);
        cycle();
        b_element_requested = 1'b0;
        checks++; if (busy !== 1'b1) begin failures++;
            $display("FAIL clr_first_accept got busy=%0b required=1", busy); end
        wait_drain("clr");
        repeat (3) cycle();
        checks++; if (returns - r0 !== 1 || b_element_valid !== 1'b0) begin failures++;
            $display("FAIL clr_no_stale got returns=%0d v=%0b required returns=1 v=0",
                     returns - r0, b_element_valid); end
    endtask

    task automatic test_back_to_back();
        int r0;
        en = 1'b1;
        r0 = returns;
        for (int i = 0; i < 12; i++) begin
            b_element_requested = 1'b1; b_element_address = 9'(10 + i); push_exp(9'(10 + i));
            cycle();
            checks++; if (req_ready !== 1'b1 || overflow !== 1'b0) begin failures++;
                $display("FAIL b2b_ready[%0d] got ready=%0b ovf=%0b required 1/0",
                         i, req_ready, overflow); end
            if (i >= 1) begin
                checks++; if (b_element_valid !== 1'b1) begin failures++;
                    $display("FAIL b2b_valid[%0d] got=%0b required=1", i, b_element_valid); end
            end
        end
        b_element_requested = 1'b0;
        wait_drain("b2b");
        checks++; if (returns - r0 !== 12) begin failures++;
            $display("FAIL b2b_return_count got=%0d required=12", returns - r0); end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_overflow();
        test_load_stall();
        test_raw();
        test_clear();
        test_back_to_back();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL final_pending got=%0d required=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
